// File: rtl/muxn_stream_pkg.sv
// muxn_stream_pkg
// Purpose: shared types for the muxn_stream slice. The mode enum takes its
// values from the encodings in muxn_defs.vh, so the enum and the header
// always agree.
// Ports: none (package).
`include "muxn_defs.vh"

package muxn_stream_pkg;

  typedef enum logic {
    MODE_FIXED_E = `MODE_FIXED,
    MODE_RR_E    = `MODE_RR
  } mode_e;

endpackage

// File: rtl/muxn_defs.vh
// muxn_defs.vh
// Shared mode encodings for the muxn_stream block. The RTL and the bench
// both include this file, so each encoding is defined in one place only.
`ifndef MUXN_DEFS_VH
`define MUXN_DEFS_VH

`define MODE_FIXED 1'b0
`define MODE_RR    1'b1

`endif

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purpose: purely combinational round-robin search. Starting at (ptr+1) mod
// CH, it searches upward and wraps past CH-1 to 0. It reports the first
// channel that is requesting. This module has no state; the caller owns the
// pointer register.
// Ports:
//   req     [CH-1:0]   per-channel request (valid) bits
//   ptr     [SELW-1:0] channel granted most recently (search starts one above)
//   gnt_idx [SELW-1:0] index of the granted channel (0 when gnt_vld=0)
//   gnt_vld            at least one channel is requesting
module rr_arbiter #(
  parameter int CH   = 4,
  parameter int SELW = 2
) (
  input  logic [CH-1:0]   req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  // The loop walks the candidates from the farthest distance to the nearest.
  // The assignment made last therefore belongs to the nearest requester after
  // ptr. This avoids a break and keeps the result independent of loop exit.
  always_comb begin
    int idx;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = CH; k >= 1; k--) begin
      idx = (int'(ptr) + k) % CH;
      if (req[idx]) begin
        gnt_idx = SELW'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/muxn_stream.sv
// muxn_stream
// Purpose: an N-to-1 stream multiplexer with a single registered output
// stage. In fixed mode the channel comes from sel. In round-robin mode the
// block rotates among the valid channels. The output register can drain and
// reload in the same cycle, so it sustains one beat per cycle.
// Ports:
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   mode               0 = fixed select via sel, 1 = round-robin
//   sel                fixed-mode channel select
//   in_valid, in_data  per-channel valid and packed data (ch i at [i*WIDTH +: WIDTH])
//   in_ready           per-channel ready, one-hot or zero
//   out_valid/out_data/out_ch  the held beat and its source channel
//   out_ready          downstream accepts the held beat
`include "muxn_defs.vh"

module muxn_stream
  import muxn_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SELW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic [SELW-1:0]     sel,
  input  logic [CH-1:0]       in_valid,
  input  logic [CH*WIDTH-1:0] in_data,
  output logic [CH-1:0]       in_ready,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic [SELW-1:0]     out_ch,
  input  logic                out_ready
);

  mode_e            cur_mode;
  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  rr_idx;
  logic             rr_vld;
  logic             fix_vld;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_vld;
  logic             can_load;
  logic             in_xfer;
  logic [WIDTH-1:0] gnt_data;

  assign cur_mode = mode_e'(mode);

  rr_arbiter #(
    .CH   (CH),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  // Fixed-mode grant. The loop compares sel with each real channel index.
  // A sel value at or above CH therefore matches nothing and gives no grant.
  // It also never indexes past in_valid.
  always_comb begin
    fix_vld = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if ((int'(sel) == i) && in_valid[i]) begin
        fix_vld = 1'b1;
      end
    end
  end

  // Grant selection and ready generation. in_ready depends only on the grant
  // and on whether the output register can take a beat. It never looks at
  // the held data. It is held at 0 while reset is asserted, because the
  // cleared output register would otherwise look loadable.
  always_comb begin
    gnt_idx  = (cur_mode == MODE_RR_E) ? rr_idx : sel;
    gnt_vld  = (cur_mode == MODE_RR_E) ? rr_vld : fix_vld;
    can_load = !out_valid || out_ready;
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (int'(gnt_idx) == i) begin
        gnt_data = in_data[i*WIDTH +: WIDTH];
        if (rst_n && gnt_vld && can_load) begin
          in_ready[i] = 1'b1;
        end
      end
    end
    in_xfer = |in_ready;
  end

  // All state lives here. Reset sets rr_ptr to CH-1, so the first
  // round-robin search starts at channel 0. An input transfer always wins
  // over a pure drain, which lets a drain and a reload share one cycle. The
  // pointer moves only when round-robin mode accepts a beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SELW'(CH - 1);
    end else begin
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_ch    <= gnt_idx;
        if (cur_mode == MODE_RR_E) begin
          rr_ptr <= gnt_idx;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muxn_stream.sv
// tb_muxn_stream
// Purpose: directed bench for muxn_stream (WIDTH=8, CH=4). Each scenario task
// drives its inputs on the falling edge. It checks in_ready just after
// driving, and checks the registered outputs 1 time unit after the rising
// edge.
`include "muxn_defs.vh"

module tb_muxn_stream;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  int vectors;
  int miscompares;

  muxn_stream #(
    .WIDTH (8),
    .CH    (4),
    .SELW  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  // Free-running clock with a period of 10 time units.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so that the run always ends, even if the simulation stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Hold reset with every channel valid. Then release between edges and
  // expect the first round-robin beat from channel 0.
  task automatic test_reset();
    rst_n     = 1'b1;
    mode      = `MODE_RR;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data   = {8'hD3, 8'hA5, 8'h3C, 8'h4B};
    #1 rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    vectors++;
    if (out_data !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_out_data: got %h expected 00", out_data);
    end
    vectors++;
    if (out_ch !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_ch: got %0d expected 0", out_ch);
    end
    vectors++;
    if (in_ready !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b expected 0000", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL release_in_ready: got %b expected 0001", in_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h4B) begin
      miscompares++;
      $display("[TB] FAIL release_first_beat: got v=%b ch=%0d d=%h expected v=1 ch=0 d=4b",
               out_valid, out_ch, out_data);
    end
  endtask

  // Fixed mode: sel=2 selects ch2, so ch2 data A5 appears one cycle later.
  // With sel=3 and only ch2 valid there is no grant.
  task automatic test_fixed();
    @(negedge clk);
    mode     = `MODE_FIXED;
    sel      = 2'd2;
    in_valid = 4'b0100;
    #1;
    vectors++;
    if (in_ready !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL fixed_in_ready: got %b expected 0100", in_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL fixed_beat: got v=%b d=%h ch=%0d expected v=1 d=a5 ch=2",
               out_valid, out_data, out_ch);
    end
    @(negedge clk);
    sel = 2'd3;
    #1;
    vectors++;
    if (in_ready !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL fixed_invalid_sel: got %b expected 0000", in_ready);
    end
  endtask

  // Load 3C from ch1, then stall the output while sel sweeps across the
  // channels. Finally release the stall and expect a drain plus an A5 reload
  // in the same cycle.
  task automatic test_backpressure();
    @(negedge clk);
    sel      = 2'd1;
    in_valid = 4'b0010;
    @(posedge clk);
    #1;
    vectors++;
    if (out_data !== 8'h3C || out_ch !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL bp_load: got d=%h ch=%0d expected d=3c ch=1", out_data, out_ch);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      sel       = 2'(i % 4);
      #1;
      vectors++;
      if (in_ready !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0000", i, in_ready);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 2'd1) begin
        miscompares++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d expected v=1 d=3c ch=1",
                 i, out_valid, out_data, out_ch);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    sel       = 2'd2;
    #1;
    vectors++;
    if (in_ready !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL bp_reload_ready: got %b expected 0100", in_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL bp_reload_beat: got v=%b d=%h ch=%0d expected v=1 d=a5 ch=2",
               out_valid, out_data, out_ch);
    end
  endtask

  // Assert reset between edges while a beat is held. The beat must vanish
  // at once, and no beat may appear after release while nothing is valid.
  task automatic test_mid_reset();
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got v=%b d=%h rdy=%b expected v=0 d=00 rdy=0000",
               out_valid, out_data, in_ready);
    end
    @(negedge clk);
    in_valid  = 4'b0000;
    mode      = `MODE_RR;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_release: got v=%b expected 0", out_valid);
    end
  endtask

  // After reset the pointer is at ch3. With all four channels valid the
  // grant walks 0,1,2,3,0,1,2,3 at one beat per cycle.
  task automatic test_round_robin();
    @(negedge clk);
    in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_ch !== 2'(k % 4) || out_data !== in_data[(k % 4)*8 +: 8]) begin
        miscompares++;
        $display("[TB] FAIL rr_seq[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                 k, out_valid, out_ch, out_data, k % 4, in_data[(k % 4)*8 +: 8]);
      end
    end
  endtask

  // With only ch1 and ch3 valid, starting from pointer 3, the grant
  // alternates 1,3,1,3. When valid drops, the output empties but keeps its
  // data and channel.
  task automatic test_sparse_rr();
    logic [1:0] exp_ch;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 4'b1010;
      exp_ch   = (k % 2 == 0) ? 2'd1 : 2'd3;
      #1;
      vectors++;
      if (in_ready !== (4'b0001 << exp_ch)) begin
        miscompares++;
        $display("[TB] FAIL sparse_ready[%0d]: got %b expected %b", k, in_ready, 4'b0001 << exp_ch);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_ch !== exp_ch) begin
        miscompares++;
        $display("[TB] FAIL sparse_ch[%0d]: got v=%b ch=%0d expected v=1 ch=%0d",
                 k, out_valid, out_ch, exp_ch);
      end
    end
    @(negedge clk);
    in_valid = 4'b0000;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_ch !== 2'd3 || out_data !== 8'hD3) begin
      miscompares++;
      $display("[TB] FAIL drain_only: got v=%b ch=%0d d=%h expected v=0 ch=3 d=d3",
               out_valid, out_ch, out_data);
    end
  endtask

  // Run the scenarios in order. Each one starts from the state the previous
  // one left behind.
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_fixed();
    test_backpressure();
    test_mid_reset();
    test_round_robin();
    test_sparse_rr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
